onchip_mem_master: RTL and testbench

Avalon-MM initiator that drives the 16-bit on-chip memory slave port (s1) of the Qsys system from user logic. Serves single-word read/write commands from the game logic at one per cycle, and runs a hardware fill engine that writes a constant value across an address range, used for board/frame clearing. Sits between the snake game FSM and the exported onchip_memory2_0_s1 conduit.

---
 rtl/onchip_mem_pkg.sv | 17 +
 rtl/onchip_mem_master_rd_valid_pipe.sv | 24 ++
 rtl/onchip_mem_master.sv | 143 ++++++++++++++
 tb/tb_onchip_mem_master.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_mem_pkg.sv
// Shared types and defaults for the on-chip memory initiator.
// Holds the FSM encoding, default widths and the all-ones byteenable.
package onchip_mem_pkg;

  localparam int DEF_ADDR_W = 22;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_BE_W   = DEF_DATA_W / 8;

  // Wide enough for any byteenable width; users truncate to their BE_W.
  localparam logic [63:0] BE_ALL = '1;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

endpackage

// File: rtl/onchip_mem_master_rd_valid_pipe.sv
// Read-response valid tracker: a read issued into the bus register emerges
// as a one-cycle valid exactly READ_LATENCY cycles after its bus cycle.
module rd_valid_pipe #(
  parameter int READ_LATENCY = 1
) (
  input  logic clk,
  input  logic clr_i,
  input  logic issue_i,
  output logic valid_o
);

  // Bit 0 lines up with the bus cycle, bit READ_LATENCY with the slave's data.
  logic [READ_LATENCY:0] vld_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the blocks are evaluated.
  always_ff @(posedge clk) begin
    if (clr_i) vld_q <= '0;
    else       vld_q <= {vld_q[READ_LATENCY-1:0], issue_i};
  end

  assign valid_o = vld_q[READ_LATENCY];

endmodule

// File: rtl/onchip_mem_master.sv
// Avalon-MM initiator for the s1 on-chip memory port: single-word commands
// from the game logic plus a constant-value fill engine for clearing.
module onchip_mem_master
  import onchip_mem_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int BE_W         = DEF_BE_W,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [BE_W-1:0]   cmd_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [ADDR_W-1:0] fill_len,
  input  logic [DATA_W-1:0] fill_value,
  output logic              fill_busy,
  output logic              fill_done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_clken,
  output logic              mem_debugaccess,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam logic [BE_W-1:0] BE_ONES = BE_W'(BE_ALL);

  state_e            state_q;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [DATA_W-1:0] fill_value_q;
  logic              fill_done_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic              mem_chipselect_q;
  logic              mem_write_q;
  logic [DATA_W-1:0] mem_writedata_q;
  logic [BE_W-1:0]   mem_byteenable_q;
  logic              cmd_accept;
  logic              rd_issue;
  logic              rd_valid;

  assign cmd_ready  = (state_q == IDLE) & ~fill_start & ~reset_reset;
  assign cmd_accept = cmd_valid & cmd_ready;
  assign rd_issue   = cmd_accept & ~cmd_write;

  // Address wraps modulo 2^ADDR_W; the count holds writes still to issue.
  assign fill_addr_d = fill_addr_q + ADDR_W'(1);
  assign fill_cnt_d  = fill_cnt_q - ADDR_W'(1);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q          <= IDLE;
      fill_addr_q      <= '0;
      fill_cnt_q       <= '0;
      fill_value_q     <= '0;
      fill_done_q      <= 1'b0;
      mem_address_q    <= '0;
      mem_chipselect_q <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_writedata_q  <= '0;
      mem_byteenable_q <= '0;
    end else begin
      mem_chipselect_q <= 1'b0;
      mem_write_q      <= 1'b0;
      fill_done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fill_start) begin
            fill_value_q <= fill_value;
            if (fill_len == '0) begin
              fill_done_q <= 1'b1;
            end else begin
              state_q          <= FILL;
              mem_chipselect_q <= 1'b1;
              mem_write_q      <= 1'b1;
              mem_address_q    <= fill_base;
              mem_writedata_q  <= fill_value;
              mem_byteenable_q <= BE_ONES;
              fill_addr_q      <= fill_base + ADDR_W'(1);
              fill_cnt_q       <= fill_len - ADDR_W'(1);
            end
          end else if (cmd_accept) begin
            mem_chipselect_q <= 1'b1;
            mem_write_q      <= cmd_write;
            mem_address_q    <= cmd_addr;
            mem_writedata_q  <= cmd_wdata;
            mem_byteenable_q <= cmd_write ? cmd_be : BE_ONES;
          end
        end
        FILL: begin
          if (fill_cnt_q == '0) begin
            state_q     <= IDLE;
            fill_done_q <= 1'b1;
          end else begin
            mem_chipselect_q <= 1'b1;
            mem_write_q      <= 1'b1;
            mem_address_q    <= fill_addr_q;
            mem_writedata_q  <= fill_value_q;
            mem_byteenable_q <= BE_ONES;
            fill_addr_q      <= fill_addr_d;
            fill_cnt_q       <= fill_cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  rd_valid_pipe #(
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_valid_pipe (
    .clk     (clk_clk),
    .clr_i   (reset_reset),
    .issue_i (rd_issue),
    .valid_o (rd_valid)
  );

  // Status outputs are forced low for as long as reset is held.
  assign rsp_valid = rd_valid & ~reset_reset;
  assign rsp_rdata = mem_readdata;
  assign fill_busy = (state_q == FILL) & ~reset_reset;
  assign fill_done = fill_done_q & ~reset_reset;

  assign mem_address     = mem_address_q;
  assign mem_chipselect  = mem_chipselect_q;
  assign mem_write       = mem_write_q;
  assign mem_writedata   = mem_writedata_q;
  assign mem_byteenable  = mem_byteenable_q;
  assign mem_clken       = 1'b1;
  assign mem_debugaccess = 1'b0;

endmodule

// File: tb/tb_onchip_mem_master.sv
// Bench for onchip_mem_master: directed scenarios with literal expectations,
// then random traffic checked every cycle against a cycle-scheduled model.
module tb_onchip_mem_master;

  localparam int RL = 1;

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [21:0] cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic [1:0]  cmd_be = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        fill_start = 1'b0;
  logic [21:0] fill_base = '0;
  logic [21:0] fill_len = '0;
  logic [15:0] fill_value = '0;
  logic        fill_busy;
  logic        fill_done;
  logic [21:0] mem_address;
  logic        mem_chipselect;
  logic        mem_write;
  logic [15:0] mem_writedata;
  logic [1:0]  mem_byteenable;
  logic        mem_clken;
  logic        mem_debugaccess;
  logic [15:0] mem_readdata = '0;

  onchip_mem_master #(.READ_LATENCY(RL)) dut (
    .clk_clk         (clk_clk),
    .reset_reset     (reset_reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_write       (cmd_write),
    .cmd_addr        (cmd_addr),
    .cmd_wdata       (cmd_wdata),
    .cmd_be          (cmd_be),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .fill_start      (fill_start),
    .fill_base       (fill_base),
    .fill_len        (fill_len),
    .fill_value      (fill_value),
    .fill_busy       (fill_busy),
    .fill_done       (fill_done),
    .mem_address     (mem_address),
    .mem_chipselect  (mem_chipselect),
    .mem_write       (mem_write),
    .mem_writedata   (mem_writedata),
    .mem_byteenable  (mem_byteenable),
    .mem_clken       (mem_clken),
    .mem_debugaccess (mem_debugaccess),
    .mem_readdata    (mem_readdata)
  );

  always #5 clk_clk = ~clk_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: cycle index, fill schedule, expected bus for this cycle.
  typedef struct {
    int          cyc;
    logic [15:0] data;
  } rsp_t;

  int          cyc = 0;
  int          f_t0 = -1;
  int          f_end = -1;
  int          done_cyc = -1;
  logic [21:0] f_base = '0;
  logic [15:0] f_val = '0;
  bit          e_cs = 1'b0;
  bit          e_we = 1'b0;
  logic [21:0] e_addr = '0;
  logic [15:0] e_wd = '0;
  logic [1:0]  e_be = '0;
  bit          model_valid = 1'b0;
  rsp_t        rsp_q[$];
  logic [15:0] ref_mem[int];
  logic [15:0] slv_mem[int];
  logic [15:0] slv_pipe[RL];
  logic [15:0] rsp_log[$];
  int          done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old_v, input logic [15:0] new_v,
                                        input logic [1:0] be);
    return {be[1] ? new_v[15:8] : old_v[15:8], be[0] ? new_v[7:0] : old_v[7:0]};
  endfunction

  function automatic logic [15:0] ref_rd(input logic [21:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000;
  endfunction

  function automatic logic [15:0] slv_rd(input logic [21:0] a);
    return slv_mem.exists(int'(a)) ? slv_mem[int'(a)] : 16'h0000;
  endfunction

  // Memory slave with READ_LATENCY cycles of read latency.
  initial begin : slave_proc
    for (int i = 0; i < RL; i++) slv_pipe[i] = 16'h0000;
    forever begin
      @(posedge clk_clk);
      for (int i = RL - 1; i > 0; i--) slv_pipe[i] = slv_pipe[i-1];
      slv_pipe[0] = (mem_chipselect && !mem_write) ? slv_rd(mem_address) : 16'hDEAD;
      if (mem_chipselect && mem_write)
        slv_mem[int'(mem_address)] = merge(slv_rd(mem_address), mem_writedata, mem_byteenable);
      mem_readdata = slv_pipe[RL-1];
    end
  end

  // Observation log used by the directed scenarios.
  initial begin : obs_proc
    forever begin
      @(negedge clk_clk);
      if (rsp_valid === 1'b1) rsp_log.push_back(rsp_rdata);
      if (fill_done === 1'b1) done_seen++;
    end
  end

  // Reference model and per-cycle compare, evaluated mid-cycle.
  initial begin : model_proc
    int          t;
    bit          rst;
    bit          idle_t;
    bit          exp_rv;
    logic [15:0] exp_d;
    rsp_t        r;
    forever begin
      @(negedge clk_clk);
      t      = cyc;
      rst    = reset_reset;
      idle_t = !(t > f_t0 && t <= f_end);
      if (model_valid) begin
        check("cmd_ready", 32'(cmd_ready), 32'(!rst && idle_t && !fill_start));
        check("fill_busy", 32'(fill_busy), 32'(!rst && !idle_t));
        check("fill_done", 32'(fill_done), 32'(!rst && t == done_cyc));
        check("mem_chipselect", 32'(mem_chipselect), 32'(e_cs));
        check("mem_write", 32'(mem_write), 32'(e_we));
        if (e_cs) begin
          check("mem_address", 32'(mem_address), 32'(e_addr));
          check("mem_byteenable", 32'(mem_byteenable), 32'(e_be));
          if (e_we) check("mem_writedata", 32'(mem_writedata), 32'(e_wd));
        end
        check("mem_clken", 32'(mem_clken), 32'd1);
        check("mem_debugaccess", 32'(mem_debugaccess), 32'd0);
        exp_rv = 1'b0;
        exp_d  = '0;
        if (rsp_q.size() != 0 && rsp_q[0].cyc == t) begin
          exp_rv = !rst;
          exp_d  = rsp_q[0].data;
          void'(rsp_q.pop_front());
        end
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (exp_rv) check("rsp_rdata", 32'(rsp_rdata), 32'(exp_d));
      end

      // Decide what the bus must show next cycle from this cycle's inputs.
      e_cs = 1'b0;
      e_we = 1'b0;
      if (rst) begin
        f_t0 = -1;
        f_end = -1;
        done_cyc = -1;
        rsp_q.delete();
      end else if (idle_t && fill_start) begin
        if (fill_len == 22'd0) begin
          done_cyc = t + 1;
        end else begin
          f_t0     = t;
          f_end    = t + int'(fill_len);
          done_cyc = f_end + 1;
          f_base   = fill_base;
          f_val    = fill_value;
        end
      end else if (idle_t && cmd_valid) begin
        e_cs   = 1'b1;
        e_we   = cmd_write;
        e_addr = cmd_addr;
        e_wd   = cmd_wdata;
        e_be   = cmd_write ? cmd_be : 2'b11;
        if (cmd_write) begin
          ref_mem[int'(cmd_addr)] = merge(ref_rd(cmd_addr), cmd_wdata, cmd_be);
        end else begin
          r.cyc  = t + 1 + RL;
          r.data = ref_rd(cmd_addr);
          rsp_q.push_back(r);
        end
      end
      if (!rst && t + 1 > f_t0 && t + 1 <= f_end) begin
        e_cs   = 1'b1;
        e_we   = 1'b1;
        e_addr = f_base + 22'(t - f_t0);
        e_wd   = f_val;
        e_be   = 2'b11;
        ref_mem[int'(e_addr)] = f_val;
      end
      cyc++;
      model_valid = 1'b1;
    end
  end

  task automatic next_cycle();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid  = 1'b0;
    fill_start = 1'b0;
  endtask

  task automatic put_cmd(input bit we, input logic [21:0] a, input logic [15:0] d,
                         input logic [1:0] be);
    cmd_valid = 1'b1;
    cmd_write = we;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_be    = be;
  endtask

  task automatic put_fill(input logic [21:0] base, input logic [21:0] len, input logic [15:0] val);
    fill_start = 1'b1;
    fill_base  = base;
    fill_len   = len;
    fill_value = val;
  endtask

  // Four-word fill with a competing command in the start cycle.
  task automatic check_fill(input logic [21:0] base, input logic [15:0] val,
                            input logic [21:0] exp_a[4]);
    next_cycle();
    put_fill(base, 22'd4, val);
    put_cmd(1'b1, 22'h0003FF, 16'h1111, 2'b11);
    @(negedge clk_clk);
    check("fill_start_blocks_cmd", 32'(cmd_ready), 32'd0);
    next_cycle();
    fill_start = 1'b0;
    put_cmd(1'b0, 22'h000000, 16'h0000, 2'b00);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_clk);
      check("fill_addr", 32'(mem_address), 32'(exp_a[k]));
      check("fill_wr", 32'({mem_chipselect, mem_write, mem_byteenable}), 32'b1111);
      check("fill_data", 32'(mem_writedata), 32'(val));
      check("fill_ready_low", 32'(cmd_ready), 32'd0);
      next_cycle();
    end
    cmd_valid = 1'b0;
    @(negedge clk_clk);
    check("fill_done_pulse", 32'({fill_done, cmd_ready, fill_busy}), 32'b110);
  endtask

  initial begin : stim_proc
    logic [21:0] exp_a[4];
    int          r;
    int          done_before;

    repeat (3) next_cycle();
    @(negedge clk_clk);
    check("rst_outputs", 32'({cmd_ready, mem_chipselect, mem_write, fill_busy, fill_done, rsp_valid}), 32'd0);
    check("rst_clken", 32'(mem_clken), 32'd1);
    next_cycle();
    reset_reset = 1'b0;

    // Write then read back one word.
    next_cycle();
    put_cmd(1'b1, 22'h000010, 16'hBEEF, 2'b11);
    next_cycle();
    put_cmd(1'b0, 22'h000010, 16'h0000, 2'b00);
    next_cycle();
    idle_inputs();
    @(negedge clk_clk);
    check("rd_bus", 32'({mem_chipselect, mem_write, mem_address}), 32'({1'b1, 1'b0, 22'h000010}));
    check("rd_not_early", 32'(rsp_valid), 32'd0);
    next_cycle();
    @(negedge clk_clk);
    check("rd_latency", 32'(rsp_valid), 32'd1);
    check("rd_data", 32'(rsp_rdata), 32'h0000BEEF);

    // Preload 0..7 with addr*3, then eight back-to-back reads.
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      put_cmd(1'b1, 22'(i), 16'(i * 3), 2'b11);
    end
    next_cycle();
    rsp_log.delete();
    put_cmd(1'b0, 22'd0, 16'h0000, 2'b00);
    for (int i = 1; i < 8; i++) begin
      next_cycle();
      put_cmd(1'b0, 22'(i), 16'h0000, 2'b00);
    end
    next_cycle();
    idle_inputs();
    repeat (4) next_cycle();
    check("burst_count", 32'(rsp_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < rsp_log.size(); i++)
      check("burst_data", 32'(rsp_log[i]), 32'(i * 3));

    // Fills: plain, across the top of the address space, and zero length.
    exp_a = '{22'h000100, 22'h000101, 22'h000102, 22'h000103};
    check_fill(22'h000100, 16'h5A5A, exp_a);
    exp_a = '{22'h3FFFFE, 22'h3FFFFF, 22'h000000, 22'h000001};
    check_fill(22'h3FFFFE, 16'hC3C3, exp_a);
    next_cycle();
    put_fill(22'h000200, 22'd0, 16'h7777);
    next_cycle();
    fill_start = 1'b0;
    @(negedge clk_clk);
    check("len0_done", 32'({fill_done, mem_chipselect, fill_busy}), 32'b100);

    // Reset while write 2 of a 10-word fill is on the bus.
    next_cycle();
    put_fill(22'h000200, 22'd10, 16'h1234);
    next_cycle();
    fill_start = 1'b0;
    next_cycle();
    next_cycle();
    reset_reset = 1'b1;
    @(negedge clk_clk);
    check("rst_fill_w2", 32'(mem_address), 32'h00000202);
    done_before = done_seen;
    next_cycle();
    reset_reset = 1'b0;
    @(negedge clk_clk);
    check("rst_fill_stop", 32'({mem_chipselect, fill_busy}), 32'd0);
    repeat (14) next_cycle();
    check("rst_no_done", 32'(done_seen - done_before), 32'd0);

    // A read in flight when reset hits is dropped.
    next_cycle();
    rsp_log.delete();
    put_cmd(1'b0, 22'h000010, 16'h0000, 2'b00);
    next_cycle();
    idle_inputs();
    reset_reset = 1'b1;
    next_cycle();
    reset_reset = 1'b0;
    repeat (4) next_cycle();
    check("rst_drop_rsp", 32'(rsp_log.size()), 32'd0);

    // Random traffic against the model.
    repeat (3000) begin
      next_cycle();
      idle_inputs();
      reset_reset = ($urandom_range(0, 299) == 0);
      r = int'($urandom_range(0, 99));
      if (r < 5) begin
        if ($urandom_range(0, 3) == 0)
          put_fill(22'h3FFFF8 + 22'($urandom_range(0, 7)), 22'($urandom_range(0, 12)), 16'($urandom));
        else
          put_fill(22'($urandom_range(0, 63)), 22'($urandom_range(0, 12)), 16'($urandom));
      end
      if (r < 8 || r >= 25)
        put_cmd(1'($urandom_range(0, 1)), 22'($urandom_range(0, 63)), 16'($urandom),
                2'($urandom_range(0, 3)));
    end

    next_cycle();
    idle_inputs();
    reset_reset = 1'b0;
    repeat (20) next_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
